// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM constants and capture FSM state type
package pwm_pkg;

    localparam int          CNT_W_DEF   = 16;
    localparam logic [15:0] TIMEOUT_DEF = 16'd60000;
    localparam int          GEN_PERIOD  = 50000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW,
        STUCK
    } cap_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// rtl/pwm_in_sync.sv - two-flop synchronizer with registered edge detect
module pwm_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic s_meta;
    logic s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            s_meta <= pwm_in;
            s      <= s_meta;
            s_d    <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period capture with stuck-line timeout
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    cap_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] h;
    logic             s, rise, fall;
    logic             timeout;
    logic             cnt_load, cap_h, pub_meas, pub_stuck, clr_stuck;

    pwm_in_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    assign timeout = (cnt == TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Rise is tested before timeout so an edge landing on the limit is a normal edge.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cap_h     = 1'b0;
        pub_meas  = 1'b0;
        pub_stuck = 1'b0;
        clr_stuck = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            clr_stuck = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt_load  = 1'b1;
                    state_nxt = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_load  = 1'b1;
                        state_nxt = MEAS_HIGH;
                    end else if (timeout) begin
                        pub_stuck = 1'b1;
                        state_nxt = STUCK;
                    end
                end
                MEAS_HIGH: begin
                    if (timeout) begin
                        pub_stuck = 1'b1;
                        state_nxt = STUCK;
                    end else if (fall) begin
                        cap_h     = 1'b1;
                        state_nxt = MEAS_LOW;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        cnt_load  = 1'b1;
                        pub_meas  = 1'b1;
                        state_nxt = MEAS_HIGH;
                    end else if (timeout) begin
                        pub_stuck = 1'b1;
                        state_nxt = STUCK;
                    end
                end
                STUCK: begin
                    if (rise) begin
                        cnt_load  = 1'b1;
                        clr_stuck = 1'b1;
                        state_nxt = MEAS_HIGH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Saturating so a long stuck interval cannot wrap back through TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt <= '0;
        else if (cnt_load)     cnt <= CNT_W'(1);
        else if (cnt != '1)    cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h           <= '0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= pub_meas | pub_stuck;
            if (cap_h) h <= cnt;
            if (pub_meas) begin
                high_cnt   <= h;
                period_cnt <= cnt;
            end
            if (pub_stuck) begin
                high_cnt    <= s ? TIMEOUT : '0;
                period_cnt  <= TIMEOUT;
                stuck       <= 1'b1;
                stuck_level <= s;
            end else if (clr_stuck) begin
                stuck <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

    localparam logic [15:0] TO  = 16'd400;
    localparam int          TOI = 400;

    logic        clk = 1'b0;
    logic        rst_n, en, pwm_in;
    logic [15:0] high_cnt, period_cnt;
    logic        meas_valid, stuck, stuck_level;

    pwm_capture #(.CNT_W(16), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pwm_in      (pwm_in),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .meas_valid  (meas_valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: timestamps of driven edges, periods computed by subtraction.
    int          t = 0;
    int          t_rise = 0;
    int          deadline = 0;
    int          h_m = 0;
    bit          armed = 0, stk = 0, rose = 0, fell = 0, line = 0, lvl_m = 0;
    logic [15:0] exp_h[$], exp_p[$];
    logic [15:0] last_h = '0, last_p = '0;

    logic [15:0] obs_h[$], obs_p[$];
    int          obs_idx = 0;
    logic [15:0] prev_h = '0, prev_p = '0;
    logic        prev_rst = 1'b0;
    logic        unstable = 1'b0;

    always @(negedge clk) begin
        if (meas_valid) begin
            obs_h.push_back(high_cnt);
            obs_p.push_back(period_cnt);
        end
        if (rst_n && prev_rst && !meas_valid &&
            (high_cnt !== prev_h || period_cnt !== prev_p))
            unstable <= 1'b1;
        prev_h   <= high_cnt;
        prev_p   <= period_cnt;
        prev_rst <= rst_n;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int hh, input int pp);
        exp_h.push_back(16'(hh));
        exp_p.push_back(16'(pp));
        last_h = 16'(hh);
        last_p = 16'(pp);
    endtask

    task automatic seg(input bit lvl, input int n);
        if (lvl && !line && armed) begin
            if (stk)               stk = 0;
            else if (rose && fell) push(h_m, t - t_rise);
            rose = 1; fell = 0; t_rise = t; deadline = t + TOI;
        end else if (!lvl && line && armed && !stk && rose && !fell) begin
            h_m  = t - t_rise;
            fell = 1;
        end
        line   = lvl;
        pwm_in = lvl;
        if (armed && !stk && deadline <= t + n - 1) begin
            push(lvl ? TOI : 0, TOI);
            stk = 1; lvl_m = lvl; rose = 0;
        end
        repeat (n) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic en_on();
        en = 1'b1;
        armed = 1; stk = 0; rose = 0; fell = 0;
        deadline = t + TOI - 2;
    endtask

    task automatic en_off();
        en = 1'b0;
        armed = 0; stk = 0;
    endtask

    task automatic run_fixed(input int n, input int hh, input int pp);
        for (int i = 0; i < n; i++) begin
            seg(1, hh);
            seg(0, pp - hh);
        end
    endtask

    task automatic run_rand(input int n);
        for (int i = 0; i < n; i++) begin
            int pp = $urandom_range(TOI - 20, 2);
            int hh = $urandom_range(pp - 1, 1);
            seg(1, hh);
            seg(0, pp - hh);
        end
    endtask

    task automatic check_meas(input string tag);
        int n_obs = obs_h.size() - obs_idx;
        chk({tag, " count"}, 16'(n_obs), 16'(exp_h.size()));
        while (exp_h.size() > 0 && obs_idx < obs_h.size()) begin
            chk({tag, " high_cnt"},   obs_h[obs_idx], exp_h.pop_front());
            chk({tag, " period_cnt"}, obs_p[obs_idx], exp_p.pop_front());
            obs_idx++;
        end
        exp_h.delete();
        exp_p.delete();
        obs_idx = obs_h.size();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst high_cnt", high_cnt, 16'd0);
        chk("rst period_cnt", period_cnt, 16'd0);
        chk("rst meas_valid", 16'(meas_valid), 16'd0);
        chk("rst stuck", 16'(stuck), 16'd0);
        chk("rst stuck_level", 16'(stuck_level), 16'd0);
        rst_n = 1'b1;
        seg(0, 5);

        // Nominal periods, the rise-at-limit boundary, random periods, then stuck low.
        en_on();
        seg(0, 20);
        run_fixed(3, 10, 252);
        run_fixed(1, 200, TOI);
        run_rand(6);
        seg(0, TOI + 50);
        chk("stuck low", 16'(stuck), 16'(stk));
        chk("stuck low level", 16'(stuck_level), 16'(lvl_m));
        seg(0, 2 * TOI);
        check_meas("phase_a");

        // Recovery from stuck, then stuck high from MEAS_HIGH, then minimum pulses.
        seg(1, 10);
        chk("stuck clear", 16'(stuck), 16'(stk));
        seg(1, TOI + 90);
        chk("stuck high", 16'(stuck), 16'(stk));
        chk("stuck high level", 16'(stuck_level), 16'(lvl_m));
        seg(0, 20);
        run_fixed(6, 1, 10);
        run_rand(5);
        seg(0, 10);
        check_meas("phase_b");

        // Enable dropped mid low phase: period abandoned, outputs hold.
        seg(1, 7);
        seg(0, 15);
        en_off();
        seg(0, 30);
        chk("en off stuck", 16'(stuck), 16'd0);
        chk("en off hold high", high_cnt, last_h);
        chk("en off hold period", period_cnt, last_p);
        en_on();
        seg(0, 20);
        run_rand(4);
        seg(0, 10);
        check_meas("phase_c");

        // Enabled while the line is already high: stuck from WAIT_RISE.
        en_off();
        seg(1, 10);
        en_on();
        seg(1, TOI + 100);
        chk("wait stuck", 16'(stuck), 16'(stk));
        chk("wait stuck level", 16'(stuck_level), 16'(lvl_m));
        seg(0, 20);
        run_rand(3);
        seg(0, 10);
        check_meas("phase_d");

        // Asynchronous reset mid high phase.
        seg(1, 10);
        check_meas("phase_e pre");
        rst_n = 1'b0;
        armed = 0; stk = 0; lvl_m = 0;
        last_h = '0; last_p = '0;
        #1;
        chk("arst high_cnt", high_cnt, 16'd0);
        chk("arst period_cnt", period_cnt, 16'd0);
        chk("arst stuck", 16'(stuck), 16'd0);
        chk("arst stuck_level", 16'(stuck_level), 16'd0);
        en = 1'b0;
        @(posedge clk);
        #1;
        t++;
        rst_n = 1'b1;
        seg(0, 10);
        run_fixed(3, 20, 100);
        seg(0, TOI + 50);
        chk("idle stuck", 16'(stuck), 16'd0);
        chk("idle high_cnt", high_cnt, 16'd0);
        check_meas("phase_e idle");
        en_on();
        seg(0, 10);
        run_rand(4);
        seg(0, TOI + 50);
        chk("final stuck", 16'(stuck), 16'(stk));
        chk("final stuck level", 16'(stuck_level), 16'(lvl_m));
        check_meas("phase_e run");

        chk("outputs stable between pulses", 16'(unstable), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
